// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the micro-MIPS multicycle control unit.
// Holds the opcode and funct encodings, ALU control codes, the ALU-op class
// handed to the ALU decoder, the datapath mux select codes and the FSM state
// encoding.
package mips_pkg;

    // Instruction opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // ALU operation class passed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath mux select codes
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encoding; codes 12-15 are unused
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // True for every opcode the control unit knows how to sequence
    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational ALU control decoder.
// Ports:
//   alu_op        in  2  operation class from the FSM (add / sub / use funct)
//   funct         in  6  instr[5:0]
//   alu_control   out 3  ALU operation code
//   funct_illegal out 1  funct not supported while alu_op selects funct
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    // An unsupported funct falls back to add so the ALU output stays defined.
    always_comb begin
        alu_control   = ALUC_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore-style multicycle control FSM for micro-MIPS
// (lw, sw, add/sub/and/or/slt, beq, addi, j).
// Optional feature macro: MIPS_CTRL_MEM_WAIT_EN adds a mem_ready input that
// stalls FETCH, MEMRD and MEMWR until memory responds.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   mem_ready             memory handshake (only with MIPS_CTRL_MEM_WAIT_EN)
//   opcode, funct         instruction fields from the instruction register
//   zero_flag             ALU zero flag, used only in BRANCH
//   alu_control           ALU operation code
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_src, pc_en         PC source select and enable
//   ir_write, i_or_d      instruction register enable, memory address select
//   mem_write, reg_write  memory write strobe, register file write enable
//   reg_dst, mem_to_reg   register file destination / data selects
//   illegal_op            one-cycle pulse on unsupported opcode or funct
//   state_dbg             current state code
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MIPS_CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero_flag,
    output logic [2:0]         alu_control,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     state;
    state_t     next_state;
    logic       mem_go;
    logic [1:0] alu_op;
    logic       funct_illegal;
    logic       pc_write;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    mips_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Unused state codes fall through the default back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = mem_go ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = mem_go ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = funct_illegal ? S_FETCH : S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // FETCH only commits the instruction and PC update once memory responds.
    always_comb begin
        alu_op        = ALUOP_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REG;
        pc_src        = PCSRC_ALU;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        i_or_d        = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_raw   = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                ir_write_raw = mem_go;
                pc_write     = mem_go;
            end
            S_DECODE: begin
                alu_src_b   = SRCB_IMM_SH2;
                illegal_raw = !is_supported_op(opcode);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                i_or_d        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = SRCA_REG;
                alu_op      = ALUOP_FUNCT;
                illegal_raw = funct_illegal;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held.
    assign pc_en      = rst_n & (pc_write | (branch & zero_flag));
    assign ir_write   = rst_n & ir_write_raw;
    assign mem_write  = rst_n & mem_write_raw;
    assign reg_write  = rst_n & reg_write_raw;
    assign illegal_op = rst_n & illegal_raw;
    assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: self-checking bench for mips_multicycle_ctrl.
// A per-instruction reference model derives cycle counts and the cycles in
// which each strobe must fire; randomized instruction streams are compared
// against it, plus directed reset, branch and illegal-instruction scenarios.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero_flag = 1'b0;
`ifdef MIPS_CTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int last_n;
    logic [3:0] last_trace [16];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MIPS_CTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .opcode      (opcode),
        .funct       (funct),
        .zero_flag   (zero_flag),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .ir_write    (ir_write),
        .i_or_d      (i_or_d),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    // Reference model: instruction-level view of the control unit
    function automatic bit legal_funct(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h02;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23:   return 5;
            6'h2B:   return 4;
            6'h00:   return legal_funct(fn) ? 4 : 3;
            6'h08:   return 4;
            6'h04:   return 3;
            6'h02:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit writes_reg(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h23 || op == 6'h08 || (op == 6'h00 && legal_funct(fn));
    endfunction

    // Runs one instruction from a FETCH negedge back to the next FETCH.
    // zero_flag is random every cycle except the third, where zf_branch is used.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zf_branch, input string name);
        int n_exp;
        int n_obs;
        bit done;
        logic [15:0] irw, rw, mw, pe, il;
        logic [15:0] e_irw, e_rw, e_mw, e_pe, e_il;
        logic [2:0] aluc2, e_aluc2;
        logic [1:0] psrc2, e_psrc2;
        logic md_wb, rd_wb;
        n_exp = exp_cycles(op, fn);
        n_obs = 0;
        done = 1'b0;
        irw = '0; rw = '0; mw = '0; pe = '0; il = '0;
        aluc2 = 3'b0; psrc2 = 2'b0; md_wb = 1'b0; rd_wb = 1'b0;
        opcode = op;
        funct = fn;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            zero_flag = (cyc == 2) ? zf_branch : 1'($urandom_range(0, 1));
            if (cyc > 0) @(negedge clk);
            else #1;
            if (cyc > 0 && state_dbg == 4'd0) begin
                done = 1'b1;
                n_obs = cyc;
                break;
            end
            last_trace[cyc] = state_dbg;
            irw[cyc] = ir_write;
            rw[cyc] = reg_write;
            mw[cyc] = mem_write;
            pe[cyc] = pc_en;
            il[cyc] = illegal_op;
            if (cyc == 2) begin
                aluc2 = alu_control;
                psrc2 = pc_src;
            end
            if (reg_write) begin
                md_wb = mem_to_reg;
                rd_wb = reg_dst;
            end
        end
        last_n = n_obs;

        e_irw = 16'h0001;
        e_rw = writes_reg(op, fn) ? (16'h1 << (n_exp - 1)) : 16'h0;
        e_mw = (op == 6'h2B) ? 16'h0008 : 16'h0;
        e_pe = 16'h0001;
        if (op == 6'h02 || (op == 6'h04 && zf_branch)) e_pe = e_pe | 16'h0004;
        e_il = 16'h0;
        if (!legal_op(op)) e_il = 16'h0002;
        else if (op == 6'h00 && !legal_funct(fn)) e_il = 16'h0004;
        e_aluc2 = (op == 6'h04) ? 3'b110 : (op == 6'h00) ? funct_alu(fn) : 3'b010;
        e_psrc2 = (op == 6'h04) ? 2'b01 : (op == 6'h02) ? 2'b10 : 2'b00;

        checks++;
        if (!done || n_obs != n_exp) begin
            errors++;
            $display("[TB] FAIL %s cycles: got %0d (returned=%0d) expected %0d", name, n_obs, done, n_exp);
        end
        checks++;
        if (irw !== e_irw) begin
            errors++;
            $display("[TB] FAIL %s ir_write cycles: got %h expected %h", name, irw, e_irw);
        end
        checks++;
        if (rw !== e_rw) begin
            errors++;
            $display("[TB] FAIL %s reg_write cycles: got %h expected %h", name, rw, e_rw);
        end
        checks++;
        if (mw !== e_mw) begin
            errors++;
            $display("[TB] FAIL %s mem_write cycles: got %h expected %h", name, mw, e_mw);
        end
        checks++;
        if (pe !== e_pe) begin
            errors++;
            $display("[TB] FAIL %s pc_en cycles: got %h expected %h", name, pe, e_pe);
        end
        checks++;
        if (il !== e_il) begin
            errors++;
            $display("[TB] FAIL %s illegal_op cycles: got %h expected %h", name, il, e_il);
        end
        if (n_exp > 2) begin
            checks++;
            if (aluc2 !== e_aluc2) begin
                errors++;
                $display("[TB] FAIL %s alu_control: got %b expected %b", name, aluc2, e_aluc2);
            end
            checks++;
            if (psrc2 !== e_psrc2) begin
                errors++;
                $display("[TB] FAIL %s pc_src: got %b expected %b", name, psrc2, e_psrc2);
            end
        end
        if (writes_reg(op, fn)) begin
            checks++;
            if (md_wb !== (op == 6'h23) || rd_wb !== (op == 6'h00)) begin
                errors++;
                $display("[TB] FAIL %s writeback selects: got mem_to_reg=%b reg_dst=%b expected %b %b",
                         name, md_wb, rd_wb, op == 6'h23, op == 6'h00);
            end
        end
    endtask

    task automatic test_reset();
        opcode = 6'($urandom_range(0, 63));
        #2;
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset state: got %0d expected 0", state_dbg);
        end
        checks++;
        if ({pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset enables: got %b expected 00000",
                     {pc_en, ir_write, mem_write, reg_write, illegal_op});
        end
        checks++;
        if (alu_control !== 3'b010 || alu_src_b !== 2'b01 || alu_src_a !== 1'b0 || pc_src !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset fetch selects: got aluc=%b srcb=%b srca=%b pcsrc=%b expected 010 01 0 00",
                     alu_control, alu_src_b, alu_src_a, pc_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_tr [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        bit ok;
        run_instr(6'h23, 6'($urandom_range(0, 63)), 1'b0, "lw");
        ok = (last_n == 5);
        for (int i = 0; i < 5; i++) if (last_trace[i] !== exp_tr[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL lw state trace: got %0d %0d %0d %0d %0d expected 0 1 2 3 4",
                     last_trace[0], last_trace[1], last_trace[2], last_trace[3], last_trace[4]);
        end
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h22, 1'b1, "rtype_sub");
        run_instr(6'h00, 6'h2A, 1'b0, "rtype_slt");
        run_instr(6'h00, 6'h24, 1'b1, "rtype_and");
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20, 1'b1, "illegal_opcode");
        run_instr(6'h00, 6'h27, 1'b1, "illegal_funct");
    endtask

    task automatic test_reset_mid_sw();
        bit found;
        found = 1'b0;
        opcode = 6'h2B;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (state_dbg == 4'd5 && mem_write) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL sw reach MEMWR: got state %0d mem_write=%b expected 5 1", state_dbg, mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state_dbg !== 4'd0 || reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset mid-sw: got mem_write=%b state=%0d reg_write=%b expected 0 0 0",
                     mem_write, state_dbg, reg_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (state_dbg !== 4'd0 || pc_en !== 1'b1 || ir_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release after reset: got state=%0d pc_en=%b ir_write=%b expected 0 1 1",
                     state_dbg, pc_en, ir_write);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] op, fn;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 6) == 0) begin
                op = 6'($urandom_range(0, 63));
                if (legal_op(op)) op = 6'h3F;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), "random");
        end
    endtask

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // Fixed-length walk with a mem_ready pattern; returns cycles and strobe masks.
    task automatic wait_walk(input logic [5:0] op, input logic [15:0] ready_mask,
                             output int n, output logic [15:0] irw, output logic [15:0] mw);
        bit left;
        left = 1'b0;
        n = 0;
        irw = '0;
        mw = '0;
        opcode = op;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            mem_ready = ready_mask[cyc];
            if (cyc > 0) @(negedge clk);
            else #1;
            if (left && state_dbg == 4'd0) begin
                n = cyc;
                break;
            end
            if (state_dbg != 4'd0) left = 1'b1;
            irw[cyc] = ir_write;
            mw[cyc] = mem_write;
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_mem_wait();
        int n;
        logic [15:0] irw, mw;
        wait_walk(6'h23, 16'hFFF8, n, irw, mw);
        checks++;
        if (n != 8 || irw !== 16'h0008) begin
            errors++;
            $display("[TB] FAIL lw fetch wait: got cycles=%0d ir_write=%h expected 8 0008", n, irw);
        end
        wait_walk(6'h2B, 16'hFFE7, n, irw, mw);
        checks++;
        if (n != 6 || mw !== 16'h0038) begin
            errors++;
            $display("[TB] FAIL sw write wait: got cycles=%0d mem_write=%h expected 6 0038", n, mw);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_mid_sw();
        test_random();
`ifdef MIPS_CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
